// File: rtl/datapath_regfile_pkg.sv
// Shared micro-op encodings between the control unit and the datapath register file:
// load-strobe bit positions, bus source codes, ALU ops, increment and clear codes.
package dp_defs;

  localparam int WE_W  = 13;
  localparam int WE_ARB = 12;
  localparam int WE_AR  = 11;
  localparam int WE_PC  = 10;
  localparam int WE_DR  = 9;
  localparam int WE_IR  = 8;
  localparam int WE_R   = 7;
  localparam int WE_TR  = 6;
  localparam int WE_AC  = 5;
  localparam int WE_R1  = 4;
  localparam int WE_R2  = 3;
  localparam int WE_RI  = 2;
  localparam int WE_RJ  = 1;
  localparam int WE_RK  = 0;

  typedef enum logic [3:0] {
    BUS_IMEM = 4'd0,
    BUS_DMEM = 4'd1,
    BUS_PC   = 4'd2,
    BUS_DR   = 4'd3,
    BUS_R    = 4'd4,
    BUS_AC   = 4'd5,
    BUS_TR   = 4'd6,
    BUS_R1   = 4'd7,
    BUS_R2   = 4'd8,
    BUS_RI   = 4'd9,
    BUS_RJ   = 4'd10,
    BUS_RK   = 4'd11
  } bus_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_PASS = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    INC_NONE  = 2'b00,
    INC_PC    = 2'b01,
    INC_AC    = 2'b10,
    INC_NONE2 = 2'b11
  } inc_op_e;

  localparam int CLR_W  = 3;
  localparam int CLR_PC = 0;
  localparam int CLR_TR = 1;
  localparam int CLR_AC = 2;

endpackage

// File: rtl/datapath_alu.sv
// Accumulator ALU: combinational, results wrap modulo 2^DATA_W with no flags.
// Unlisted op codes leave the accumulator unchanged.
module datapath_alu
  import dp_defs::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        alu_mode,
  output logic [DATA_W-1:0] result
);

  // Keeps only the low DATA_W bits of a double-width product.
  function automatic logic [DATA_W-1:0] wrap_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return full[DATA_W-1:0];
  endfunction

  always_comb begin
    result = ac;
    case (alu_mode)
      ALU_ADD:  result = ac + operand;
      ALU_SUB:  result = ac - operand;
      ALU_MUL:  result = wrap_mul(ac, operand);
      ALU_PASS: result = operand;
      default:  result = ac;
    endcase
  end

endmodule

// File: rtl/datapath_regfile.sv
// Register file and shared bus of the matrix-multiplier core; executes the control
// unit's per-cycle load/inc/clr micro-ops and returns ir and the registered zero flag.
module datapath_regfile
  import dp_defs::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WE_W-1:0]   write_en,
  input  logic [3:0]        bus_ld,
  input  logic [1:0]        inc,
  input  logic [CLR_W-1:0]  clr,
  input  logic [3:0]        alu_mode,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        ir,
  output logic              z,
  output logic [DATA_W-1:0] ac
);

  localparam logic [DATA_W-1:0] AC_ONE = 1;
  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  logic [ADDR_W-1:0] arb_q, ar_q, pc_q;
  logic [DATA_W-1:0] dr_q, r_q, tr_q, ac_q;
  logic [DATA_W-1:0] r1_q, r2_q, ri_q, rj_q, rk_q;
  logic [7:0]        ir_q;
  logic              z_q;

  logic [DATA_W-1:0] bus_val;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ac_next;
  logic              ac_upd;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_upd;
  logic [DATA_W-1:0] tr_next;
  logic              tr_upd;

  // Bus source mux: reads always see the registered (pre-edge) values.
  always_comb begin
    bus_val = '0;
    case (bus_ld)
      BUS_IMEM: bus_val = imem_rdata;
      BUS_DMEM: bus_val = dmem_rdata;
      BUS_PC:   bus_val = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      BUS_DR:   bus_val = dr_q;
      BUS_R:    bus_val = r_q;
      BUS_AC:   bus_val = ac_q;
      BUS_TR:   bus_val = tr_q;
      BUS_R1:   bus_val = r1_q;
      BUS_R2:   bus_val = r2_q;
      BUS_RI:   bus_val = ri_q;
      BUS_RJ:   bus_val = rj_q;
      BUS_RK:   bus_val = rk_q;
      default:  bus_val = '0;
    endcase
  end

  datapath_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .ac       (ac_q),
    .operand  (bus_val),
    .alu_mode (alu_mode),
    .result   (alu_res)
  );

  // Per-register priority for AC, PC and TR: clear, then load, then increment.
  always_comb begin
    ac_next = ac_q;
    ac_upd  = 1'b0;
    if (clr[CLR_AC]) begin
      ac_next = '0;
      ac_upd  = 1'b1;
    end else if (write_en[WE_AC]) begin
      ac_next = alu_res;
      ac_upd  = 1'b1;
    end else if (inc == INC_AC) begin
      ac_next = ac_q + AC_ONE;
      ac_upd  = 1'b1;
    end
  end

  always_comb begin
    pc_next = pc_q;
    pc_upd  = 1'b0;
    if (clr[CLR_PC]) begin
      pc_next = '0;
      pc_upd  = 1'b1;
    end else if (write_en[WE_PC]) begin
      pc_next = bus_val[ADDR_W-1:0];
      pc_upd  = 1'b1;
    end else if (inc == INC_PC) begin
      pc_next = pc_q + PC_ONE;
      pc_upd  = 1'b1;
    end
  end

  always_comb begin
    tr_next = tr_q;
    tr_upd  = 1'b0;
    if (clr[CLR_TR]) begin
      tr_next = '0;
      tr_upd  = 1'b1;
    end else if (write_en[WE_TR]) begin
      tr_next = bus_val;
      tr_upd  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q <= '0;
      ar_q  <= '0;
      pc_q  <= '0;
      dr_q  <= '0;
      ir_q  <= '0;
      r_q   <= '0;
      tr_q  <= '0;
      ac_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      ri_q  <= '0;
      rj_q  <= '0;
      rk_q  <= '0;
      z_q   <= 1'b1;
    end else begin
      if (write_en[WE_ARB]) arb_q <= bus_val[ADDR_W-1:0];
      if (write_en[WE_AR])  ar_q  <= bus_val[ADDR_W-1:0];
      if (write_en[WE_DR])  dr_q  <= bus_val;
      if (write_en[WE_IR])  ir_q  <= bus_val[7:0];
      if (write_en[WE_R])   r_q   <= bus_val;
      if (write_en[WE_R1])  r1_q  <= bus_val;
      if (write_en[WE_R2])  r2_q  <= bus_val;
      if (write_en[WE_RI])  ri_q  <= bus_val;
      if (write_en[WE_RJ])  rj_q  <= bus_val;
      if (write_en[WE_RK])  rk_q  <= bus_val;
      if (pc_upd)           pc_q  <= pc_next;
      if (tr_upd)           tr_q  <= tr_next;
      // z tracks the value AC is about to take, so it lines up with AC after the edge.
      if (ac_upd) begin
        ac_q <= ac_next;
        z_q  <= (ac_next == '0);
      end
    end
  end

  assign bus       = bus_val;
  assign imem_addr = ar_q;
  assign dmem_addr = arb_q;
  assign ir        = ir_q;
  assign z         = z_q;
  assign ac        = ac_q;

endmodule

// File: tb/tb_datapath_regfile.sv
// Directed bench for datapath_regfile: fetch, ALU, wrap, priority, multi-load and reset.
module tb_datapath_regfile;

  logic        clk;
  logic        rst_n;
  logic [12:0] write_en;
  logic [3:0]  bus_ld;
  logic [1:0]  inc;
  logic [2:0]  clr;
  logic [3:0]  alu_mode;
  logic [15:0] imem_rdata;
  logic [15:0] dmem_rdata;
  logic [15:0] bus;
  logic [7:0]  imem_addr;
  logic [7:0]  dmem_addr;
  logic [7:0]  ir;
  logic        z;
  logic [15:0] ac;

  int compared;
  int mismatched;

  datapath_regfile #(
    .DATA_W(16),
    .ADDR_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (write_en),
    .bus_ld     (bus_ld),
    .inc        (inc),
    .clr        (clr),
    .alu_mode   (alu_mode),
    .imem_rdata (imem_rdata),
    .dmem_rdata (dmem_rdata),
    .bus        (bus),
    .imem_addr  (imem_addr),
    .dmem_addr  (dmem_addr),
    .ir         (ir),
    .z          (z),
    .ac         (ac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    write_en = '0;
    bus_ld   = 4'd0;
    inc      = 2'b00;
    clr      = 3'b000;
    alu_mode = 4'd3;
  endtask

  // Loads val from imem_rdata into every register selected by we (AC via pass-through).
  task automatic load(input logic [12:0] we, input logic [15:0] val);
    idle();
    imem_rdata = val;
    alu_mode   = 4'd5;
    write_en   = we;
    tick();
    idle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    imem_rdata = '0;
    dmem_rdata = 16'hBEEF;
    idle();
    #12;
    chk("rst_ac", ac, 16'h0);
    chk("rst_z", z, 1'b1);
    chk("rst_imem_addr", imem_addr, 8'h0);
    chk("rst_dmem_addr", dmem_addr, 8'h0);
    chk("rst_ir", ir, 8'h0);
    bus_ld = 4'd5;
    #1;
    chk("rst_bus_ac", bus, 16'h0);
    idle();
    rst_n = 1'b1;
    tick();

    // Fetch
    load(13'h1 << 10, 16'h0005);
    bus_ld   = 4'd2;
    write_en = 13'h1 << 11;
    #1;
    chk("fetch_bus_pc", bus, 16'h0005);
    tick();
    chk("fetch_imem_addr", imem_addr, 8'h05);
    imem_rdata = 16'h001B;
    bus_ld     = 4'd0;
    write_en   = 13'h1 << 9;
    tick();
    bus_ld   = 4'd3;
    write_en = 13'h1 << 8;
    #1;
    chk("fetch_bus_dr", bus, 16'h001B);
    tick();
    chk("fetch_ir", ir, 8'h1B);
    idle();

    // ALU
    load(13'h1 << 5, 16'd7);
    load(13'h1 << 7, 16'd3);
    bus_ld   = 4'd4;
    write_en = 13'h1 << 5;
    alu_mode = 4'd2;
    tick();
    chk("alu_mul", ac, 16'd21);
    chk("alu_mul_z", z, 1'b0);
    imem_rdata = 16'd21;
    bus_ld     = 4'd0;
    alu_mode   = 4'd1;
    tick();
    chk("alu_sub", ac, 16'd0);
    chk("alu_sub_z", z, 1'b1);
    load(13'h1 << 5, 16'hFFFF);
    chk("alu_pass_z", z, 1'b0);
    imem_rdata = 16'd1;
    bus_ld     = 4'd0;
    write_en   = 13'h1 << 5;
    alu_mode   = 4'd0;
    tick();
    chk("alu_add_wrap", ac, 16'h0);
    chk("alu_add_wrap_z", z, 1'b1);
    load(13'h1 << 5, 16'h0009);
    bus_ld   = 4'd5;
    write_en = 13'h1 << 5;
    alu_mode = 4'd0;
    tick();
    chk("alu_self_add_old", ac, 16'h0012);
    imem_rdata = 16'h7777;
    bus_ld     = 4'd0;
    alu_mode   = 4'd3;
    tick();
    chk("alu_nop_code", ac, 16'h0012);
    load(13'h1 << 5, 16'h0100);
    load(13'h1 << 7, 16'h0100);
    bus_ld   = 4'd4;
    write_en = 13'h1 << 5;
    alu_mode = 4'd2;
    tick();
    chk("alu_mul_trunc", ac, 16'h0000);
    idle();

    // Increment wrap
    load(13'h1 << 10, 16'h00FF);
    inc = 2'b01;
    tick();
    idle();
    bus_ld = 4'd2;
    #1;
    chk("inc_pc_wrap", bus, 16'h0000);
    inc = 2'b01;
    tick();
    bus_ld = 4'd2;
    inc    = 2'b00;
    #1;
    chk("inc_pc_plain", bus, 16'h0001);
    load(13'h1 << 5, 16'hFFFF);
    inc = 2'b10;
    tick();
    chk("inc_ac_wrap", ac, 16'h0);
    chk("inc_ac_wrap_z", z, 1'b1);
    idle();

    // Priority
    load(13'h1 << 10, 16'h0033);
    imem_rdata = 16'h0040;
    bus_ld     = 4'd0;
    write_en   = 13'h1 << 10;
    inc        = 2'b01;
    tick();
    idle();
    bus_ld = 4'd2;
    #1;
    chk("prio_load_over_inc", bus, 16'h0040);
    imem_rdata = 16'h0040;
    bus_ld     = 4'd0;
    write_en   = 13'h1 << 10;
    inc        = 2'b01;
    clr        = 3'b001;
    tick();
    idle();
    bus_ld = 4'd2;
    #1;
    chk("prio_clr_pc", bus, 16'h0000);
    load(13'h1 << 6, 16'h0055);
    load(13'h1 << 5, 16'h0077);
    clr = 3'b110;
    tick();
    idle();
    chk("prio_clr_ac", ac, 16'h0);
    chk("prio_clr_ac_z", z, 1'b1);
    bus_ld = 4'd6;
    #1;
    chk("prio_clr_tr", bus, 16'h0);
    idle();

    // Multi-load and illegal select
    load(13'h1 << 4, 16'h0012);
    bus_ld   = 4'd7;
    write_en = 13'b1100000000000;
    tick();
    idle();
    chk("multi_ar", imem_addr, 8'h12);
    chk("multi_arb", dmem_addr, 8'h12);
    bus_ld = 4'd13;
    #1;
    chk("bus_illegal_13", bus, 16'h0);
    bus_ld = 4'd1;
    #1;
    chk("bus_dmem", bus, 16'hBEEF);
    idle();

    // Asynchronous reset mid-cycle with registers loaded
    load(13'h1 << 5, 16'h0ABC);
    load(13'h1 << 11, 16'h0034);
    load(13'h1 << 12, 16'h0056);
    load(13'h1 << 8, 16'h00C3);
    chk("pre_rst_ac", ac, 16'h0ABC);
    chk("pre_rst_ir", ir, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ac", ac, 16'h0);
    chk("mid_rst_z", z, 1'b1);
    chk("mid_rst_imem_addr", imem_addr, 8'h0);
    chk("mid_rst_dmem_addr", dmem_addr, 8'h0);
    chk("mid_rst_ir", ir, 8'h0);
    bus_ld = 4'd5;
    #1;
    chk("mid_rst_bus_ac", bus, 16'h0);
    idle();
    #3;
    rst_n = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
